md_unit: RTL and testbench

//   Multiply/divide unit (HI/LO) in the EX stage of the 5-stage MIPS pipeline.

---
 rtl/md_unit.sv | 125 ++++++++++++
 tb/tb_md_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the EX stage: mult/multu/div/divu run for a
// fixed number of busy cycles, while mthi/mtlo write HI/LO on a single edge.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_Start_i,
  input  logic [2:0]  EX_MDOp_i,
  input  logic [31:0] EX_A_i,
  input  logic [31:0] EX_B_i,
  output logic        md_start_o,
  output logic        md_busy_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  // Returns {HI, LO}; the low 64 bits of a product of sign/zero-extended operands.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [63:0] ax, bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}; signed division works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with no overflow special case.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic        neg_a, neg_b;
    logic [31:0] ma, mb, q, r;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (32'd0 - a) : a;
    mb    = neg_b ? (32'd0 - b) : b;
    if (mb == 32'd0) mb = 32'd1;
    q     = ma / mb;
    r     = ma % mb;
    if (neg_a ^ neg_b) q = 32'd0 - q;
    if (neg_a)         r = 32'd0 - r;
    return {r, q};
  endfunction

  assign md_busy_o  = (state_q == BUSY);
  assign md_start_o = EX_Start_i && !EX_MDOp_i[2] && !md_busy_o;
  assign HI_o       = hi_q;
  assign LO_o       = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (EX_Start_i) begin
          case (EX_MDOp_i)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_d     = EX_A_i;
              b_d     = EX_B_i;
              op_d    = EX_MDOp_i[1:0];
              cnt_d   = EX_MDOp_i[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = BUSY;
            end
            3'd4:    hi_d = EX_A_i;
            3'd5:    lo_d = EX_A_i;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Starts arriving while busy are deliberately not looked at here.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!op_q[1]) begin
            {hi_d, lo_d} = mul_fn(a_q, b_q, !op_q[0]);
          end else if (b_q != 32'd0) begin
            {hi_d, lo_d} = div_fn(a_q, b_q, !op_q[0]);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares on each busy fall or mthi/mtlo write.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_Start_i;
  logic [2:0]  EX_MDOp_i;
  logic [31:0] EX_A_i, EX_B_i;
  logic        md_start_o, md_busy_o;
  logic [31:0] HI_o, LO_o;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .EX_Start_i(EX_Start_i), .EX_MDOp_i(EX_MDOp_i),
    .EX_A_i(EX_A_i), .EX_B_i(EX_B_i), .md_start_o(md_start_o),
    .md_busy_o(md_busy_o), .HI_o(HI_o), .LO_o(LO_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural HI/LO semantics with 64-bit integer arithmetic.
  task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned pu;
    exp_t            e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.len = 0;
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; e.len = MC; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; e.len = MC; end
      3'd2: begin
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
        e.len = DC;
      end
      3'd3: begin
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
        e.len = DC;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    if (op <= 3'd5) sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit busy_now);
    EX_Start_i = 1'b1;
    EX_MDOp_i  = op;
    EX_A_i     = a;
    EX_B_i     = b;
    #1;
    chk("md_start", {63'd0, md_start_o}, {63'd0, (op <= 3'd3) && !busy_now});
    if (!busy_now) model_push(op, a, b);
    @(posedge clk); #1;
    EX_Start_i = 1'b0;
    EX_MDOp_i  = 3'($urandom_range(0, 7));
    EX_A_i     = $urandom;
    EX_B_i     = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (md_busy_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (md_busy_o) chk("busy_timeout", {63'd0, md_busy_o}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic pop_cmp(input string tag, input int len);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_unexpected: got completion, want none (t=%0t)", tag, $time);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_hi"},  {32'd0, HI_o}, {32'd0, e.hi});
      chk({tag, "_lo"},  {32'd0, LO_o}, {32'd0, e.lo});
      chk({tag, "_len"}, 64'(len), 64'(e.len));
    end
  endtask

  // Monitor
  initial begin
    bit prev_busy = 1'b0;
    bit mt_pend   = 1'b0;
    int blen      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        mt_pend   = 1'b0;
        blen      = 0;
      end else begin
        if (mt_pend) begin
          chk("mt_busy", {63'd0, md_busy_o}, 64'd0);
          pop_cmp("mt", 0);
        end
        if (prev_busy && !md_busy_o) pop_cmp("md", blen);
        blen      = md_busy_o ? blen + 1 : 0;
        mt_pend   = EX_Start_i && (EX_MDOp_i == 3'd4 || EX_MDOp_i == 3'd5) && !md_busy_o;
        prev_busy = md_busy_o;
      end
    end
  end

  // Stimulus
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    EX_Start_i = 1'b0;
    EX_MDOp_i  = 3'd7;
    EX_A_i     = 32'd0;
    EX_B_i     = 32'd0;
    rst_n      = 1'b0;
    #2;
    chk("rst_busy", {63'd0, md_busy_o}, 64'd0);
    chk("rst_hi", {32'd0, HI_o}, 64'd0);
    chk("rst_lo", {32'd0, LO_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 0); wait_idle();
    chk("mult_hi_const", {32'd0, HI_o}, 64'hFFFF_FFFF);
    chk("mult_lo_const", {32'd0, LO_o}, 64'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 0); wait_idle();
    chk("multu_hi_const", {32'd0, HI_o}, 64'h1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0); wait_idle();
    chk("div_lo_const", {32'd0, LO_o}, 64'hFFFF_FFFD);
    chk("div_hi_const", {32'd0, HI_o}, 64'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2, 0); wait_idle();
    issue(3'd4, 32'h1234, 32'd0, 0);
    chk("mthi_const", {32'd0, HI_o}, 64'h1234);
    issue(3'd5, 32'h55, 32'd0, 0);
    issue(3'd2, 32'd100, 32'd0, 0); wait_idle();
    chk("div0_lo_const", {32'd0, LO_o}, 64'h55);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_idle();

    issue(3'd2, 32'd1000, 32'd7, 0);
    repeat (2) begin @(posedge clk); #1; end
    issue(3'd0, 32'h0BAD_0BAD, 32'h1357_2468, 1);
    wait_idle();
    issue(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0); wait_idle();
    issue(3'd6, 32'hDEAD_BEEF, 32'd3, 0);
    issue(3'd7, 32'hCAFE_F00D, 32'd3, 0);

    issue(3'd0, 32'h0001_0000, 32'h0001_0000, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, md_busy_o}, 64'd0);
    chk("arst_hi", {32'd0, HI_o}, 64'd0);
    chk("arst_lo", {32'd0, LO_o}, 64'd0);
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    chk("post_rst_busy", {63'd0, md_busy_o}, 64'd0);
    chk("post_rst_hi", {32'd0, HI_o}, 64'd0);
    chk("post_rst_lo", {32'd0, LO_o}, 64'd0);

    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      issue(op, a, b, 0);
      if (op <= 3'd3 && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        issue(3'($urandom_range(0, 7)), $urandom, $urandom, 1);
      end
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
